pkt_rr_arb: RTL

Packet-granular round-robin arbiter that drains N upstream `fifo_80x8`-style FIFOs into one downstream FIFO of the same type. It drives upstream pops directly from their `rdata`/`empty`, holds a grant from SOP to EOP, and writes a registered output stage that obeys downstream `full`/`afull`. It sits between per-source frame builders (ICMP reply, ARP reply) and the shared MAC TX FIFO.

---
 rtl/pkt_rr_arb_pkg.sv | 18 +
 rtl/pkt_rr_arb_if.sv | 36 +++
 rtl/pkt_rr_arb_rr_pick.sv | 37 +++
 rtl/pkt_rr_arb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pkt_rr_arb_pkg.sv
// pkt_rr_arb_pkg
//   Shared constants and types for the packet round-robin arbiter.
//   W_WORD  : width of one FIFO word
//   SOP_BIT : start-of-packet flag position inside a word
//   EOP_BIT : end-of-packet flag position inside a word
//   state_t : arbiter state (IDLE waits for a SOP head, BUSY owns a packet)
package pkt_rr_arb_pkg;

  localparam int W_WORD  = 80;
  localparam int SOP_BIT = 79;
  localparam int EOP_BIT = 78;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/pkt_rr_arb_if.sv
// pkt_rr_arb_if
//   Bundles the upstream FIFO read side and the downstream FIFO write side.
//   in_rdata  : head words of all upstream FIFOs, source i at [i*W +: W]
//   in_empty  : upstream empty flags
//   in_rval   : upstream pop strobes (driven by the arbiter)
//   out_wdata : word written downstream (driven by the arbiter)
//   out_wval  : downstream write strobe (driven by the arbiter)
//   out_full  : downstream full
//   out_afull : downstream almost-full
//   master = arbiter side, slave = FIFO/environment side.
interface pkt_rr_arb_if
  import pkt_rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = W_WORD
);

  logic [N*W-1:0] in_rdata;
  logic [N-1:0]   in_empty;
  logic [N-1:0]   in_rval;
  logic [W-1:0]   out_wdata;
  logic           out_wval;
  logic           out_full;
  logic           out_afull;

  modport master (
    input  in_rdata, in_empty, out_full, out_afull,
    output in_rval, out_wdata, out_wval
  );

  modport slave (
    output in_rdata, in_empty, out_full, out_afull,
    input  in_rval, out_wdata, out_wval
  );

endinterface

// File: rtl/pkt_rr_arb_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans requests starting one past the
//   pointer and wrapping, so the pointer position itself has lowest priority.
//   i_req   : request vector
//   i_ptr   : index of the most recent winner
//   o_grant : one-hot winner (zero when no request)
//   o_any   : at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic          o_any
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // First request found walking upward from i_ptr+1 wins.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/pkt_rr_arb.sv
// pkt_rr_arb
//   Packet-granular round-robin arbiter draining N upstream FIFOs into one
//   downstream FIFO. A grant is held from SOP to EOP; headless (SOP=0) words
//   seen while idle are discarded and counted.
//   clk, arst_n : clock, asynchronous active-low reset
//   i_en        : allows new grants (a packet in progress always completes)
//   bus         : upstream pops / downstream writes (master modport)
//   o_grant     : one-hot registered packet owner, zero when idle
//   o_busy      : a packet is in progress
//   o_drop_cnt  : saturating count of discarded orphan words
//   o_pkt_cnt   : wrapping count of forwarded EOP words
module pkt_rr_arb
  import pkt_rr_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = W_WORD
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_en,
  pkt_rr_arb_if.master  bus,
  output logic [N-1:0]  o_grant,
  output logic          o_busy,
  output logic [15:0]   o_drop_cnt,
  output logic [15:0]   o_pkt_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t        r_state;
  logic [PW-1:0] r_rrPtr;
  logic [N-1:0]  r_grant;
  logic [W-1:0]  r_wdata;
  logic          r_wval;
  logic [15:0]   r_dropCnt;
  logic [15:0]   r_pktCnt;

  logic          w_space;
  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_orph;
  logic [N-1:0]  w_pickOh;
  logic          w_pickAny;
  logic          w_grantReady;
  logic [N-1:0]  w_pop;
  logic          w_fwd;
  logic          w_drop;
  logic [W-1:0]  w_selWord;
  logic [PW-1:0] w_selIdx;

  // With almost-full set, only write when nothing is already in flight in
  // the output register; that single word always fits in the last slot.
  assign w_space = !bus.out_afull | (!r_wval & !bus.out_full);

  // Classify each upstream head as a packet start or an orphan.
  always_comb begin
    w_cand = '0;
    w_orph = '0;
    for (int i = 0; i < N; i++) begin
      w_cand[i] = !bus.in_empty[i] &  bus.in_rdata[i*W + SOP_BIT];
      w_orph[i] = !bus.in_empty[i] & !bus.in_rdata[i*W + SOP_BIT];
    end
  end

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .i_req   (w_cand),
    .i_ptr   (r_rrPtr),
    .o_grant (w_pickOh),
    .o_any   (w_pickAny)
  );

  assign w_grantReady = |(r_grant & ~bus.in_empty);

  // Pop decision. Orphan discard only happens in IDLE when no grant is
  // issued, and it bypasses both enable and downstream space.
  always_comb begin
    w_pop  = '0;
    w_fwd  = 1'b0;
    w_drop = 1'b0;
    if (r_state == IDLE) begin
      if (i_en && w_space && w_pickAny) begin
        w_pop = w_pickOh;
        w_fwd = 1'b1;
      end else if (|w_orph) begin
        w_pop  = w_orph & ~(w_orph - N'(1));
        w_drop = 1'b1;
      end
    end else if (w_grantReady && w_space) begin
      w_pop = r_grant;
      w_fwd = 1'b1;
    end
  end

  // Mux the popped word and encode its source index.
  always_comb begin
    w_selWord = '0;
    w_selIdx  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pop[i]) begin
        w_selWord = w_selWord | bus.in_rdata[i*W +: W];
        w_selIdx  = PW'(i);
      end
    end
  end

  // Pops are suppressed while reset is held so the shared FIFOs stay intact.
  assign bus.in_rval = w_pop & {N{arst_n}};

  // State, output stage and counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= IDLE;
      r_rrPtr   <= PW'(N - 1);
      r_grant   <= '0;
      r_wdata   <= '0;
      r_wval    <= 1'b0;
      r_dropCnt <= '0;
      r_pktCnt  <= '0;
    end else begin
      r_wval <= w_fwd;
      if (w_fwd) begin
        r_wdata <= w_selWord;
      end
      if (w_drop && (r_dropCnt != 16'hFFFF)) begin
        r_dropCnt <= r_dropCnt + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_fwd) begin
            if (w_selWord[EOP_BIT]) begin
              r_rrPtr  <= w_selIdx;
              r_pktCnt <= r_pktCnt + 16'd1;
            end else begin
              r_state <= BUSY;
              r_grant <= w_pop;
            end
          end
        end
        BUSY: begin
          if (w_fwd && w_selWord[EOP_BIT]) begin
            r_state  <= IDLE;
            r_rrPtr  <= w_selIdx;
            r_grant  <= '0;
            r_pktCnt <= r_pktCnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_wdata = r_wdata;
  assign bus.out_wval  = r_wval;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state == BUSY);
  assign o_drop_cnt    = r_dropCnt;
  assign o_pkt_cnt     = r_pktCnt;

endmodule
